light_sequencer: RTL and testbench

LIGHT_SEQUENCER -- requirements
Module: light_sequencer

---
 rtl/light_pkg.sv | 11 +
 rtl/sec_tick.sv | 19 +
 rtl/light_sequencer.sv | 75 +++++++
 tb/tb_light_sequencer.sv | 100 ++++++++++
 4 files changed

// File: rtl/light_pkg.sv
// light_pkg: phase encodings and lamp one-hot patterns shared by the sequencer.
package light_pkg;
  typedef enum logic [1:0] {STANDBY = 2'd0, RED = 2'd1, GREEN = 2'd2, YELLOW = 2'd3} state_t;
  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  function automatic logic [2:0] lamp(input state_t s);
    return s == RED ? LAMP_RED : s == GREEN ? LAMP_GRN : s == YELLOW ? LAMP_YEL : LAMP_OFF;
  endfunction
endpackage

// File: rtl/sec_tick.sv
// sec_tick: one-cycle pulse every TICKS_PER_SEC cycles, restartable via clr.
module sec_tick #(
  parameter int TICKS_PER_SEC = 10000
) (
  input  logic Div_CLK,
  input  logic Rst_n,
  input  logic clr,
  output logic tick,
  output logic half
);
  localparam int W = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(TICKS_PER_SEC - 1);
  assign half = cnt < W'(TICKS_PER_SEC / 2);
  always_ff @(posedge Div_CLK) begin
    if (!Rst_n || clr || tick) cnt <= '0;
    else cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/light_sequencer.sv
// light_sequencer: red/green/yellow traffic light with standby blink and pedestrian shortening.
module light_sequencer
  import light_pkg::*;
#(
  parameter int TICKS_PER_SEC = 10000,
  parameter int RED_TIME      = 30,
  parameter int GREEN_TIME    = 25,
  parameter int YELLOW_TIME   = 5,
  parameter int PED_MIN       = 5
) (
  input  logic       Div_CLK,
  input  logic       Rst_n,
  input  logic       run_sw,
  input  logic       ped_req,
  output logic [2:0] light,
  output logic [7:0] remain,
  output logic [1:0] phase
);
  if (RED_TIME < 1 || RED_TIME > 255) begin : g_bad_red
    $error("RED_TIME out of range");
  end
  if (GREEN_TIME < 1 || GREEN_TIME > 255) begin : g_bad_green
    $error("GREEN_TIME out of range");
  end
  if (YELLOW_TIME < 1 || YELLOW_TIME > 255) begin : g_bad_yellow
    $error("YELLOW_TIME out of range");
  end
  if (PED_MIN < 1 || PED_MIN > GREEN_TIME) begin : g_bad_ped
    $error("PED_MIN out of range");
  end
  localparam logic [7:0] R8 = 8'(RED_TIME);
  localparam logic [7:0] G8 = 8'(GREEN_TIME);
  localparam logic [7:0] Y8 = 8'(YELLOW_TIME);
  localparam logic [7:0] P8 = 8'(PED_MIN);
  state_t state, nxt, adv;
  logic tick, half, clr, ped_ok;
  logic [7:0] remain_nxt;
  logic [2:0] light_nxt;
  assign phase = state;
  assign clr = nxt != state;
  sec_tick #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_tick (
    .Div_CLK(Div_CLK),
    .Rst_n  (Rst_n),
    .clr    (clr),
    .tick   (tick),
    .half   (half)
  );
  always_ff @(posedge Div_CLK) begin
    if (!Rst_n) begin
      state  <= STANDBY;
      remain <= 8'd0;
      light  <= LAMP_OFF;
    end else begin
      state  <= nxt;
      remain <= remain_nxt;
      light  <= light_nxt;
    end
  end
  always_comb begin
    adv = state == RED ? GREEN : state == GREEN ? YELLOW : RED;
    nxt = state == STANDBY ? (run_sw ? RED : STANDBY) :
          !run_sw ? STANDBY :
          (tick && remain == 8'd1) ? adv : state;
  end
  // ped shortening needs remain > PED_MIN >= 1, so it never collides with a phase advance
  always_comb begin
    ped_ok = state == GREEN && ped_req && remain > P8;
    remain_nxt = nxt == STANDBY ? 8'd0 :
                 state == STANDBY ? R8 :
                 ped_ok ? P8 :
                 nxt != state ? (nxt == GREEN ? G8 : nxt == YELLOW ? Y8 : R8) :
                 tick ? remain - 8'd1 : remain;
    light_nxt = nxt == STANDBY ? ((state == STANDBY && half) ? LAMP_YEL : LAMP_OFF) : lamp(nxt);
  end
endmodule

// File: tb/tb_light_sequencer.sv
// tb_light_sequencer: directed checks of phase timing, pedestrian requests, standby and reset.
module tb_light_sequencer;
  logic Div_CLK = 1'b0;
  logic Rst_n, run_sw, ped_req;
  logic [2:0] light;
  logic [7:0] remain;
  logic [1:0] phase;
  int n_cmp = 0;
  int n_err = 0;
  always #5 Div_CLK = ~Div_CLK;
  light_sequencer #(
    .TICKS_PER_SEC(4), .RED_TIME(3), .GREEN_TIME(4), .YELLOW_TIME(2), .PED_MIN(2)
  ) dut (
    .Div_CLK(Div_CLK), .Rst_n(Rst_n), .run_sw(run_sw), .ped_req(ped_req),
    .light(light), .remain(remain), .phase(phase)
  );
  task automatic step(input int n);
    repeat (n) @(posedge Div_CLK);
    #1;
  endtask
  task automatic test_reset;
    Rst_n = 1'b0; run_sw = 1'b0; ped_req = 1'b0;
    step(2);
    n_cmp++; if ({phase, remain, light} !== {2'd0, 8'd0, 3'b000}) begin n_err++; $display("FAIL reset got %h want %h", {phase, remain, light}, {2'd0, 8'd0, 3'b000}); end
  endtask
  task automatic test_cycle;
    run_sw = 1'b1; Rst_n = 1'b1;
    step(1);
    n_cmp++; if ({phase, remain, light} !== {2'd1, 8'd3, 3'b100}) begin n_err++; $display("FAIL red_entry got %h want %h", {phase, remain, light}, {2'd1, 8'd3, 3'b100}); end
    step(4);
    n_cmp++; if ({phase, remain, light} !== {2'd1, 8'd2, 3'b100}) begin n_err++; $display("FAIL red_dec got %h want %h", {phase, remain, light}, {2'd1, 8'd2, 3'b100}); end
    step(7);
    n_cmp++; if ({phase, remain, light} !== {2'd1, 8'd1, 3'b100}) begin n_err++; $display("FAIL red_last got %h want %h", {phase, remain, light}, {2'd1, 8'd1, 3'b100}); end
    step(1);
    n_cmp++; if ({phase, remain, light} !== {2'd2, 8'd4, 3'b001}) begin n_err++; $display("FAIL green_entry got %h want %h", {phase, remain, light}, {2'd2, 8'd4, 3'b001}); end
    step(15);
    n_cmp++; if ({phase, remain, light} !== {2'd2, 8'd1, 3'b001}) begin n_err++; $display("FAIL green_last got %h want %h", {phase, remain, light}, {2'd2, 8'd1, 3'b001}); end
    step(1);
    n_cmp++; if ({phase, remain, light} !== {2'd3, 8'd2, 3'b010}) begin n_err++; $display("FAIL yellow_entry got %h want %h", {phase, remain, light}, {2'd3, 8'd2, 3'b010}); end
    step(7);
    n_cmp++; if ({phase, remain, light} !== {2'd3, 8'd1, 3'b010}) begin n_err++; $display("FAIL yellow_last got %h want %h", {phase, remain, light}, {2'd3, 8'd1, 3'b010}); end
    step(1);
    n_cmp++; if ({phase, remain, light} !== {2'd1, 8'd3, 3'b100}) begin n_err++; $display("FAIL red_again got %h want %h", {phase, remain, light}, {2'd1, 8'd3, 3'b100}); end
  endtask
  task automatic test_ped;
    ped_req = 1'b1; step(1); ped_req = 1'b0;
    n_cmp++; if ({phase, remain, light} !== {2'd1, 8'd3, 3'b100}) begin n_err++; $display("FAIL ped_in_red got %h want %h", {phase, remain, light}, {2'd1, 8'd3, 3'b100}); end
    step(11);
    n_cmp++; if ({phase, remain, light} !== {2'd2, 8'd4, 3'b001}) begin n_err++; $display("FAIL ped_green_entry got %h want %h", {phase, remain, light}, {2'd2, 8'd4, 3'b001}); end
    ped_req = 1'b1; step(1); ped_req = 1'b0;
    n_cmp++; if ({phase, remain, light} !== {2'd2, 8'd2, 3'b001}) begin n_err++; $display("FAIL ped_shorten got %h want %h", {phase, remain, light}, {2'd2, 8'd2, 3'b001}); end
    ped_req = 1'b1; step(1); ped_req = 1'b0;
    n_cmp++; if ({phase, remain, light} !== {2'd2, 8'd2, 3'b001}) begin n_err++; $display("FAIL ped_at_min got %h want %h", {phase, remain, light}, {2'd2, 8'd2, 3'b001}); end
    step(2);
    n_cmp++; if ({phase, remain, light} !== {2'd2, 8'd1, 3'b001}) begin n_err++; $display("FAIL ped_tick_kept got %h want %h", {phase, remain, light}, {2'd2, 8'd1, 3'b001}); end
    step(3);
    n_cmp++; if ({phase, remain, light} !== {2'd2, 8'd1, 3'b001}) begin n_err++; $display("FAIL ped_before_yel got %h want %h", {phase, remain, light}, {2'd2, 8'd1, 3'b001}); end
    step(1);
    n_cmp++; if ({phase, remain, light} !== {2'd3, 8'd2, 3'b010}) begin n_err++; $display("FAIL ped_yellow got %h want %h", {phase, remain, light}, {2'd3, 8'd2, 3'b010}); end
  endtask
  task automatic test_standby;
    step(3);
    run_sw = 1'b0; step(1);
    n_cmp++; if ({phase, remain, light} !== {2'd0, 8'd0, 3'b000}) begin n_err++; $display("FAIL standby_entry got %h want %h", {phase, remain, light}, {2'd0, 8'd0, 3'b000}); end
    for (int i = 0; i < 8; i++) begin
      step(1);
      n_cmp++; if ({phase, remain, light} !== {2'd0, 8'd0, (i % 4 < 2) ? 3'b010 : 3'b000}) begin n_err++; $display("FAIL standby_blink%0d got %h want %h", i, {phase, remain, light}, {2'd0, 8'd0, (i % 4 < 2) ? 3'b010 : 3'b000}); end
    end
    run_sw = 1'b1; step(1);
    n_cmp++; if ({phase, remain, light} !== {2'd1, 8'd3, 3'b100}) begin n_err++; $display("FAIL standby_exit got %h want %h", {phase, remain, light}, {2'd1, 8'd3, 3'b100}); end
  endtask
  task automatic test_reset_mid;
    step(14);
    n_cmp++; if ({phase, remain, light} !== {2'd2, 8'd4, 3'b001}) begin n_err++; $display("FAIL mid_green got %h want %h", {phase, remain, light}, {2'd2, 8'd4, 3'b001}); end
    Rst_n = 1'b0; step(1);
    n_cmp++; if ({phase, remain, light} !== {2'd0, 8'd0, 3'b000}) begin n_err++; $display("FAIL reset_mid got %h want %h", {phase, remain, light}, {2'd0, 8'd0, 3'b000}); end
    Rst_n = 1'b1; step(1);
    n_cmp++; if ({phase, remain, light} !== {2'd1, 8'd3, 3'b100}) begin n_err++; $display("FAIL reset_release got %h want %h", {phase, remain, light}, {2'd1, 8'd3, 3'b100}); end
  endtask
  task automatic test_ped_tick;
    step(19);
    n_cmp++; if ({phase, remain, light} !== {2'd2, 8'd3, 3'b001}) begin n_err++; $display("FAIL pt_setup got %h want %h", {phase, remain, light}, {2'd2, 8'd3, 3'b001}); end
    ped_req = 1'b1; step(1); ped_req = 1'b0;
    n_cmp++; if ({phase, remain, light} !== {2'd2, 8'd2, 3'b001}) begin n_err++; $display("FAIL pt_ped_wins got %h want %h", {phase, remain, light}, {2'd2, 8'd2, 3'b001}); end
    step(4);
    n_cmp++; if ({phase, remain, light} !== {2'd2, 8'd1, 3'b001}) begin n_err++; $display("FAIL pt_next_tick got %h want %h", {phase, remain, light}, {2'd2, 8'd1, 3'b001}); end
    step(4);
    n_cmp++; if ({phase, remain, light} !== {2'd3, 8'd2, 3'b010}) begin n_err++; $display("FAIL pt_yellow got %h want %h", {phase, remain, light}, {2'd3, 8'd2, 3'b010}); end
  endtask
  initial begin
    test_reset;
    test_cycle;
    test_ped;
    test_standby;
    test_reset_mid;
    test_ped_tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
